// File: rtl/mips_mem_pkg.sv
// Shared types and default widths for the instruction/data memory port arbiter.
package mips_mem_pkg;

  localparam int ADDR_W_DEFAULT = 32;
  localparam int DATA_W_DEFAULT = 32;

  // Arbiter FSM: one WAIT state per requester while memory is busy, then a
  // one-cycle RESP state that produces the done pulse.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_IF = 3'd1,
    WAIT_D  = 3'd2,
    RESP_IF = 3'd3,
    RESP_D  = 3'd4
  } arb_state_e;

endpackage

// File: rtl/arb_streak_counter.sv
// Counts consecutive data-port grants made while the fetch port is waiting,
// so the arbiter can hand the memory to fetch once the streak is exhausted.
module arb_streak_counter #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d_grant_i,
  input  logic if_grant_i,
  input  logic if_req_i,
  output logic at_max_o
);

  localparam int CNT_W = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_D_STREAK);

  logic [CNT_W-1:0] streak_q;
  logic [CNT_W-1:0] streak_d;

  // A fetch grant or an idle fetch port ends the streak; otherwise data
  // grants accumulate and saturate at the limit.
  always_comb begin
    streak_d = streak_q;
    if (if_grant_i || !if_req_i) begin
      streak_d = '0;
    end else if (d_grant_i && (streak_q != MAX_CNT)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  // Streak register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  assign at_max_o = (streak_q == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one shared memory port.
// Data normally wins; after MAX_D_STREAK back-to-back data grants with fetch
// waiting, fetch is served next. One memory transaction is in flight at most.
//
// Handshake: a requester raises x_req with stable address/data and holds it
// until x_done pulses for one cycle; x_rdata is valid with x_done and held
// afterwards. On the memory side mem_req and its qualifiers stay stable until
// a cycle in which mem_ready is high; mem_ready seen with no grant is ignored.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEFAULT,
  parameter int DATA_W       = DATA_W_DEFAULT,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  // shared memory port
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  // debug view of the FSM
  output arb_state_e        dbg_state_o
);

  arb_state_e        state_q,     state_d;
  logic              mem_req_q,   mem_req_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;

  logic d_grant;
  logic if_grant;
  logic streak_at_max;

  // Memory is word addressed in practice; the byte-offset bits are dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

  arb_streak_counter #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_streak (
    .clock     (clock),
    .reset_n   (reset_n),
    .d_grant_i (d_grant),
    .if_grant_i(if_grant),
    .if_req_i  (if_req),
    .at_max_o  (streak_at_max)
  );

  // Next-state, grant decision and registered memory-port / read-data updates.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    d_grant     = 1'b0;
    if_grant    = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_req && !(if_req && streak_at_max)) begin
          d_grant     = 1'b1;
          state_d     = WAIT_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = {d_addr[ADDR_W-1:2], 2'b00};
          mem_wdata_d = d_wdata;
        end else if (if_req) begin
          if_grant    = 1'b1;
          state_d     = WAIT_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = {if_addr[ADDR_W-1:2], 2'b00};
          mem_wdata_d = '0;
        end
      end
      WAIT_IF: begin
        if (mem_ready) begin
          mem_req_d  = 1'b0;
          if_rdata_d = mem_rdata;
          state_d    = RESP_IF;
        end
      end
      WAIT_D: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata;
          end
          state_d = RESP_D;
        end
      end
      RESP_IF: state_d = IDLE;
      RESP_D:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight transaction.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign if_rdata    = if_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign if_done     = (state_q == RESP_IF);
  assign d_done      = (state_q == RESP_D);
  assign if_stall    = if_req & ~if_done;
  assign d_stall     = d_req & ~d_done;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory, a grant
// scoreboard and per-port read-data scoreboards.
module tb_mem_port_arbiter;
  import mips_mem_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 4;
  localparam int GW   = 1 + AW + DW;

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DUT signals ----------------
  logic          if_req  = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_done;
  logic [DW-1:0] if_rdata;
  logic          if_stall;
  logic          d_req   = 1'b0;
  logic          d_we    = 1'b0;
  logic [AW-1:0] d_addr  = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_done;
  logic [DW-1:0] d_rdata;
  logic          d_stall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  arb_state_e    dbg_state;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
    .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [GW-1:0] grant_q[$];
  logic [DW-1:0] if_exp_q[$];
  logic [DW-1:0] d_exp_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [GW-1:0] grant(input logic we, input logic [AW-1:0] a,
                                          input logic [DW-1:0] wd);
    return {we, a, wd};
  endfunction

  // ---------------- memory model + monitor ----------------
  logic [DW-1:0] mem_arr [logic [AW-1:0]];
  int            mem_lat     = 1;
  int            wait_cnt    = 0;
  logic          model_ready = 1'b0;
  logic          stray_ready = 1'b0;
  logic [DW-1:0] model_rdata = '0;

  assign mem_ready = model_ready | stray_ready;
  assign mem_rdata = stray_ready ? 32'h1234_5678 : model_rdata;

  logic          prev_req     = 1'b0;
  logic [GW-1:0] prev_grant   = '0;
  logic          prev_if_done = 1'b0;
  logic          prev_d_done  = 1'b0;

  always @(negedge clock) begin
    logic [GW-1:0] cur;
    logic [GW-1:0] exp_g;
    logic [DW-1:0] exp_d;
    cur = {mem_we, mem_addr, mem_wdata};
    // memory answers mem_lat cycles into a request (ready in the last one)
    if (mem_req) begin
      wait_cnt++;
      model_ready = (wait_cnt >= mem_lat);
      model_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : (32'hC0DE_0000 ^ mem_addr);
    end else begin
      wait_cnt    = 0;
      model_ready = 1'b0;
    end
    if (mem_req && prev_req) check("grant_stable", cur, prev_grant);
    if (mem_req && model_ready) begin
      if (mem_we) mem_arr[mem_addr] = mem_wdata;
      check("grant_expected", (grant_q.size() > 0), 1'b1);
      if (grant_q.size() > 0) begin
        exp_g = grant_q.pop_front();
        if (exp_g[GW-1]) check("grant_store", cur, exp_g);
        else             check("grant_read", cur[GW-1:DW], exp_g[GW-1:DW]);
      end
    end
    if (if_done) begin
      check("if_done_single", prev_if_done, 1'b0);
      check("if_done_expected", (if_exp_q.size() > 0), 1'b1);
      if (if_exp_q.size() > 0) begin
        exp_d = if_exp_q.pop_front();
        check("if_rdata", if_rdata, exp_d);
      end
    end
    if (d_done) begin
      check("d_done_single", prev_d_done, 1'b0);
      check("d_done_expected", (d_exp_q.size() > 0), 1'b1);
      if (d_exp_q.size() > 0) begin
        exp_d = d_exp_q.pop_front();
        check("d_rdata", d_rdata, exp_d);
      end
    end
    if (reset_n) begin
      check("if_stall", if_stall, if_req & ~if_done);
      check("d_stall", d_stall, d_req & ~d_done);
    end
    prev_req     = mem_req && !model_ready;
    prev_grant   = cur;
    prev_if_done = if_done;
    prev_d_done  = d_done;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_if_done(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!if_done && cyc < 100);
    check("if_done_timeout", if_done, 1'b1);
  endtask

  task automatic wait_d_done(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!d_done && cyc < 100);
    check("d_done_timeout", d_done, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    int n;
    int cnt;

    // reset state
    tick(3);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_if_done", if_done, 1'b0);
    check("rst_d_done", d_done, 1'b0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_state", dbg_state, IDLE);
    reset_n = 1'b1;
    tick(2);

    // fetch only, memory ready one cycle after mem_req
    mem_lat = 2;
    mem_arr[32'h10] = 32'h8C01_0004;
    grant_q.push_back(grant(1'b0, 32'h10, '0));
    if_exp_q.push_back(32'h8C01_0004);
    if_addr = 32'h10;
    if_req  = 1'b1;
    wait_if_done(cyc);
    check("fetch_latency", cyc, 3);
    check("fetch_rdata", if_rdata, 32'h8C01_0004);
    if_req = 1'b0;
    tick();
    check("fetch_done_pulse", if_done, 1'b0);
    check("fetch_rdata_held", if_rdata, 32'h8C01_0004);

    // zero-wait load: request sample to done is two cycles
    mem_lat = 1;
    mem_arr[32'h80] = 32'h1111_2222;
    grant_q.push_back(grant(1'b0, 32'h80, '0));
    d_exp_q.push_back(32'h1111_2222);
    d_addr = 32'h80;
    d_we   = 1'b0;
    d_req  = 1'b1;
    wait_d_done(cyc);
    check("load_latency", cyc, 2);
    d_req = 1'b0;
    tick();

    // simultaneous store + fetch: data first, store leaves d_rdata alone
    mem_arr[32'h14] = 32'h2402_0001;
    grant_q.push_back(grant(1'b1, 32'h40, 32'hDEAD_BEEF));
    grant_q.push_back(grant(1'b0, 32'h14, '0));
    d_exp_q.push_back(32'h1111_2222);
    if_exp_q.push_back(32'h2402_0001);
    d_addr  = 32'h40;
    d_we    = 1'b1;
    d_wdata = 32'hDEAD_BEEF;
    if_addr = 32'h14;
    d_req   = 1'b1;
    if_req  = 1'b1;
    wait_d_done(cyc);
    check("store_first_if_waiting", if_done, 1'b0);
    d_req = 1'b0;
    d_we  = 1'b0;
    wait_if_done(cyc);
    check("store_keeps_d_rdata", d_rdata, 32'h1111_2222);
    if_req = 1'b0;
    tick();

    // unaligned load with 3-cycle memory: word address held for 3 cycles
    mem_lat = 3;
    grant_q.push_back(grant(1'b0, 32'h40, '0));
    d_exp_q.push_back(32'hDEAD_BEEF);
    d_addr = 32'h43;
    d_req  = 1'b1;
    n   = 0;
    cnt = 0;
    do begin
      tick();
      n++;
      if (mem_req) begin
        cnt++;
        check("aligned_addr", mem_addr, 32'h40);
      end
    end while (!d_done && n < 100);
    check("slow_d_done", d_done, 1'b1);
    check("slow_req_cycles", cnt, 3);
    d_req = 1'b0;
    cnt = 0;
    repeat (3) begin
      tick();
      if (d_done) cnt++;
    end
    check("slow_single_done", cnt, 0);

    // fetch withdrawn mid-wait still completes
    mem_arr[32'h20] = 32'hAC22_0008;
    grant_q.push_back(grant(1'b0, 32'h20, '0));
    if_exp_q.push_back(32'hAC22_0008);
    if_addr = 32'h22;
    if_req  = 1'b1;
    tick(2);
    check("withdraw_in_wait", dbg_state, WAIT_IF);
    if_req = 1'b0;
    wait_if_done(cyc);
    check("withdraw_rdata", if_rdata, 32'hAC22_0008);
    tick();

    // streak: continuous data with fetch waiting -> 4 data grants, then fetch
    mem_lat = 1;
    mem_arr[32'h100] = 32'h5555_AAAA;
    mem_arr[32'h24]  = 32'h0800_0000;
    for (int i = 0; i < MAXS; i++) begin
      grant_q.push_back(grant(1'b0, 32'h100, '0));
      d_exp_q.push_back(32'h5555_AAAA);
    end
    grant_q.push_back(grant(1'b0, 32'h24, '0));
    if_exp_q.push_back(32'h0800_0000);
    d_addr  = 32'h100;
    if_addr = 32'h24;
    d_req   = 1'b1;
    if_req  = 1'b1;
    n   = 0;
    cnt = 0;
    do begin
      tick();
      n++;
      if (d_done) cnt++;
    end while (!if_done && n < 200);
    check("streak_fetch_done", if_done, 1'b1);
    check("streak_data_grants", cnt, MAXS);
    d_req  = 1'b0;
    if_req = 1'b0;
    tick(2);

    // stray mem_ready in IDLE is ignored
    stray_ready = 1'b1;
    tick(2);
    stray_ready = 1'b0;
    tick();
    check("stray_state", dbg_state, IDLE);
    check("stray_if_rdata", if_rdata, 32'h0800_0000);
    check("stray_d_rdata", d_rdata, 32'h5555_AAAA);

    // reset during WAIT_D abandons the load
    mem_lat = 10;
    d_addr  = 32'h200;
    d_req   = 1'b1;
    tick(2);
    check("rst_mid_state", dbg_state, WAIT_D);
    check("rst_mid_req", mem_req, 1'b1);
    reset_n = 1'b0;
    d_req   = 1'b0;
    #1;
    check("rst_mid_req_drop", mem_req, 1'b0);
    check("rst_mid_idle", dbg_state, IDLE);
    check("rst_mid_d_rdata", d_rdata, 32'h0);
    tick(2);
    reset_n = 1'b1;
    cnt = 0;
    repeat (4) begin
      tick();
      if (d_done || if_done) cnt++;
    end
    check("rst_no_done", cnt, 0);
    check("rst_release_idle", dbg_state, IDLE);

    // service resumes normally after reset
    mem_lat = 1;
    grant_q.push_back(grant(1'b0, 32'h10, '0));
    if_exp_q.push_back(32'h8C01_0004);
    if_addr = 32'h10;
    if_req  = 1'b1;
    wait_if_done(cyc);
    check("post_rst_latency", cyc, 2);
    if_req = 1'b0;
    tick(3);

    check("grant_q_empty", grant_q.size(), 0);
    check("if_exp_q_empty", if_exp_q.size(), 0);
    check("d_exp_q_empty", d_exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 32, byte-address width.
REQ-002 SHALL have parameter DATA_W, 32, word width.
REQ-003 SHALL have parameter MAX_D_STREAK, 4, max consecutive data grants while fetch waits.
REQ-004 SHALL have port clock  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port if_req  in  1  fetch request, held until if_done.
REQ-007 SHALL have port if_addr  in  ADDR_W  fetch byte address.
REQ-008 SHALL have port if_done  out  1  one-cycle completion pulse for fetch.
REQ-009 SHALL have port if_rdata  out  DATA_W  fetched word, valid with if_done, held after.
REQ-010 SHALL have port d_req  in  1  data request (LW/SW), held until d_done.
REQ-011 SHALL have port d_we  in  1  1 = store, 0 = load.
REQ-012 SHALL have port d_addr  in  ADDR_W  data byte address.
REQ-013 SHALL have port d_wdata  in  DATA_W  store data.
REQ-014 SHALL have port d_done  out  1  one-cycle completion pulse for data.
REQ-015 SHALL have port d_rdata  out  DATA_W  load word, valid with d_done, held after.
REQ-016 SHALL have ports mem_req/mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W  shared-memory request.
REQ-017 SHALL have ports mem_ready in 1, mem_rdata in DATA_W  memory completion and read data.
REQ-018 SHALL have ports if_stall, d_stall  out  1  = req & ~done, for pipeline freeze.

Function
REQ-019 SHALL implement FSM states IDLE, WAIT_IF, WAIT_D, RESP_IF, RESP_D.
REQ-020 IDLE: d_req only -> WAIT_D; if_req only -> WAIT_IF; both -> WAIT_D unless streak==MAX_D_STREAK, then WAIT_IF; none -> IDLE.
REQ-021 Grant SHALL be registered: mem_req high from cycle after the sampling edge, held with mem_we/mem_addr/mem_wdata stable until mem_ready.
REQ-022 mem_addr SHALL be requester address with bits [1:0] forced to 0; mem_we SHALL be 0 for fetch, d_we for data.
REQ-023 WAIT_x with mem_ready=1: mem_req drops next cycle, mem_rdata captured into x_rdata (loads/fetches only; stores leave d_rdata unchanged), -> RESP_x.
REQ-024 RESP_x SHALL pulse x_done for exactly one cycle, then -> IDLE; minimum latency req-sample to done = 2 cycles (zero-wait memory).
REQ-025 Requester SHALL drop or renew req the cycle after done; back-to-back request served from next IDLE.
REQ-026 Streak counter SHALL increment (saturating at MAX_D_STREAK) on data grant while if_req high, clear on fetch grant or when if_req low.
REQ-027 Request withdrawn mid-WAIT SHALL NOT abort; transaction completes and done still pulses.
REQ-028 mem_ready outside WAIT_x SHALL be ignored.
REQ-029 Only one memory transaction SHALL be outstanding at any time.

Reset
REQ-030 reset_n low SHALL immediately force IDLE, mem_req/mem_we/if_done/d_done=0, mem_addr/mem_wdata/if_rdata/d_rdata=0, streak=0.
REQ-031 Reset mid-WAIT SHALL abandon the transaction; no done pulse after release.

Structure
REQ-032 Package mips_mem_pkg SHALL hold the FSM state typedef and ADDR_W/DATA_W defaults.
REQ-033 Streak logic SHALL be sub-module arb_streak_counter; FSM and datapath stay in mem_port_arbiter.

Verification
REQ-034 Fetch only, if_addr=0x0000_0010, mem_ready 1 cycle after mem_req, mem_rdata=0x8C01_0004 -> mem_addr=0x10, mem_we=0, if_done 1 cycle, if_rdata=0x8C01_0004.
REQ-035 Simultaneous if_req and d_req (store, d_addr=0x40, d_wdata=0xDEAD_BEEF) -> data first (mem_we=1), fetch second; d_rdata unchanged.
REQ-036 d_req held continuously, if_req high, MAX_D_STREAK=4 -> exactly 4 data grants then one fetch grant.
REQ-037 d_addr=0x0000_0043, 3-cycle memory latency -> mem_addr=0x40 stable for 3 cycles, d_done exactly once.
REQ-038 reset_n low during WAIT_D -> mem_req 0 immediately; after release no d_done, FSM in IDLE, next request served normally.
REQ-039 Stray mem_ready in IDLE -> no done pulse, no rdata change.
